// File: rtl/table_fsm_pkg.sv
// Shared types for table_fsm: transition-table entry layout and default table contents.
// Entries hold up to TBL_MAX_W bits of next state; instances narrower than that zero-extend.
package table_fsm_pkg;

  localparam int TBL_MAX_W = 8;

  typedef struct packed {
    logic [TBL_MAX_W-1:0] next;
    logic                 flag;
  } tbl_entry_t;

  // Default table walks the states in a ring: i -> (i+1) mod n, flag clear.
  function automatic tbl_entry_t tbl_default(input int unsigned idx, input int unsigned n);
    tbl_entry_t e;
    e.next = TBL_MAX_W'((idx + 1) % n);
    e.flag = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/table_fsm_ram.sv
// Transition-table storage: sync write, async read, ring-table init on reset.
// Latency: read combinational, write visible the cycle after the strobe; backpressure: none.
module fsm_table_ram
  import table_fsm_pkg::*;
#(
  parameter int STATE_W    = 3,
  parameter int NUM_STATES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [STATE_W-1:0] wr_addr,
  input  tbl_entry_t         wr_entry,
  input  logic [STATE_W-1:0] rd_addr,
  output tbl_entry_t         rd_entry
);

  localparam logic [STATE_W:0] NUM_S = NUM_STATES[STATE_W:0];

  tbl_entry_t mem [NUM_STATES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        mem[i] <= tbl_default(i, NUM_STATES);
      end
    end else if (we) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  // Out-of-range addresses read as zero; the caller treats that state as illegal anyway.
  always_comb begin
    rd_entry = '0;
    if ({1'b0, rd_addr} < NUM_S) begin
      rd_entry = mem[rd_addr];
    end
  end

endmodule

// File: rtl/table_fsm.sv
// Table-driven FSM with run-time programmable transitions, per-state flag and step counter.
// Latency: state registered, y/stuck combinational from state; backpressure: none (en gates steps).
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int STATE_W     = 3,
  parameter int NUM_STATES  = 8,
  parameter int RESET_STATE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               restart,
  input  logic               wr_en,
  input  logic [STATE_W-1:0] wr_addr,
  input  logic [STATE_W-1:0] wr_next,
  input  logic               wr_flag,
  input  logic               clr_cnt,
  output logic [STATE_W-1:0] state,
  output logic               y,
  output logic               stuck,
  output logic               wr_err,
  output logic [15:0]        step_cnt
);

  localparam logic [STATE_W:0]   NUM_S = NUM_STATES[STATE_W:0];
  localparam logic [STATE_W-1:0] RST_S = RESET_STATE[STATE_W-1:0];

  tbl_entry_t         cur;
  tbl_entry_t         wr_entry;
  logic               wr_ok;
  logic               state_legal;
  logic [STATE_W-1:0] state_nxt;
  logic [15:0]        cnt_nxt;

  assign wr_ok         = wr_en && ({1'b0, wr_addr} < NUM_S) && ({1'b0, wr_next} < NUM_S);
  assign wr_entry.next = TBL_MAX_W'(wr_next);
  assign wr_entry.flag = wr_flag;

  fsm_table_ram #(
    .STATE_W    (STATE_W),
    .NUM_STATES (NUM_STATES)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .we       (wr_ok),
    .wr_addr  (wr_addr),
    .wr_entry (wr_entry),
    .rd_addr  (state),
    .rd_entry (cur)
  );

  assign state_legal = ({1'b0, state} < NUM_S);
  assign y           = cur.flag;
  assign stuck       = (cur.next == TBL_MAX_W'(state));

  // cur is the pre-write entry, so a same-cycle write to table[state] only affects later steps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = step_cnt;
    if (!state_legal || restart) begin
      state_nxt = RST_S;
    end else if (en) begin
      state_nxt = cur.next[STATE_W-1:0];
    end
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if (en && !restart && (step_cnt != 16'hFFFF)) begin
      cnt_nxt = step_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RST_S;
      step_cnt <= '0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= cnt_nxt;
      wr_err   <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_table_fsm.sv
// Directed bench for table_fsm: default 8-state instance plus a 6-state instance for range rejection.
module tb_table_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, restart, wr_en, wr_flag, clr_cnt;
  logic [2:0] wr_addr, wr_next;
  logic [2:0] state;
  logic       y, stuck, wr_err;
  logic [15:0] step_cnt;

  logic       en6, wr_en6;
  logic [2:0] wr_addr6, wr_next6;
  logic [2:0] state6;
  logic       y6, stuck6, wr_err6;
  logic [15:0] step_cnt6;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  table_fsm u_dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_next(wr_next), .wr_flag(wr_flag), .clr_cnt(clr_cnt),
    .state(state), .y(y), .stuck(stuck), .wr_err(wr_err), .step_cnt(step_cnt)
  );

  table_fsm #(.STATE_W(3), .NUM_STATES(6), .RESET_STATE(1)) u_dut6 (
    .clk(clk), .reset(reset), .en(en6), .restart(1'b0), .wr_en(wr_en6),
    .wr_addr(wr_addr6), .wr_next(wr_next6), .wr_flag(1'b0), .clr_cnt(1'b0),
    .state(state6), .y(y6), .stuck(stuck6), .wr_err(wr_err6), .step_cnt(step_cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [2:0] n, input logic f);
    wr_en = 1'b1; wr_addr = a; wr_next = n; wr_flag = f;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [2:0] seq_ring [8];
    logic [2:0] seq_prog [6];
    logic       flag_prog [6];
    logic [2:0] seq6 [6];
    seq_ring  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    seq_prog  = '{3'd5, 3'd7, 3'd3, 3'd2, 3'd3, 3'd2};
    flag_prog = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    seq6      = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

    reset = 1'b1; en = 0; restart = 0; wr_en = 0; wr_flag = 0; clr_cnt = 0;
    wr_addr = '0; wr_next = '0;
    en6 = 0; wr_en6 = 0; wr_addr6 = '0; wr_next6 = '0;
    tick();
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_cnt", 32'(step_cnt), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    reset = 1'b0;

    // Default ring table: 1,2,...,7,0,1
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ring_state%0d", i), 32'(state), 32'(seq_ring[i]));
      chk($sformatf("ring_y%0d", i), 32'(y), 32'd0);
    end
    chk("ring_cnt", 32'(step_cnt), 32'd8);
    en = 1'b0;

    // Program a custom graph
    wr(3'd1, 3'd5, 1'b0);
    chk("wr_ok_no_err", 32'(wr_err), 32'd0);
    wr(3'd5, 3'd7, 1'b1);
    wr(3'd7, 3'd3, 1'b1);
    wr(3'd3, 3'd2, 1'b0);
    wr(3'd2, 3'd3, 1'b0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_cnt", 32'(step_cnt), 32'd8);
    chk("prog_y_s1", 32'(y), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("prog_state%0d", i), 32'(state), 32'(seq_prog[i]));
      chk($sformatf("prog_y%0d", i), 32'(y), 32'(flag_prog[i]));
    end
    chk("prog_cnt", 32'(step_cnt), 32'd14);

    // restart beats en
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_prio_state", 32'(state), 32'd1);
    chk("restart_prio_cnt", 32'(step_cnt), 32'd14);
    en = 1'b0;

    // Self-loop at 4
    wr(3'd4, 3'd4, 1'b0);
    wr(3'd1, 3'd4, 1'b0);
    en = 1'b1;
    tick();
    chk("stuck_state", 32'(state), 32'd4);
    chk("stuck_flag", 32'(stuck), 32'd1);
    chk("stuck_cnt0", 32'(step_cnt), 32'd15);
    tick();
    tick();
    chk("stuck_hold", 32'(state), 32'd4);
    chk("stuck_cnt2", 32'(step_cnt), 32'd17);

    // clr_cnt wins over increment
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt", 32'(step_cnt), 32'd0);

    // Same-cycle write to table[state] with en: old entry (4->4) taken
    wr(3'd4, 3'd6, 1'b1);
    chk("wr_same_state", 32'(state), 32'd4);
    chk("wr_same_y_new", 32'(y), 32'd1);
    chk("wr_same_stuck_new", 32'(stuck), 32'd0);
    chk("wr_same_cnt", 32'(step_cnt), 32'd1);
    tick();
    chk("wr_same_next", 32'(state), 32'd6);
    chk("wr_same_cnt2", 32'(step_cnt), 32'd2);
    en = 1'b0;

    // 6-state instance: out-of-range writes rejected
    wr_en6 = 1'b1; wr_addr6 = 3'd2; wr_next6 = 3'd7;
    tick();
    wr_en6 = 1'b0;
    chk("err_next_pulse", 32'(wr_err6), 32'd1);
    tick();
    chk("err_next_clear", 32'(wr_err6), 32'd0);
    wr_en6 = 1'b1; wr_addr6 = 3'd6; wr_next6 = 3'd1;
    tick();
    wr_en6 = 1'b0;
    chk("err_addr_pulse", 32'(wr_err6), 32'd1);
    tick();
    chk("err_addr_clear", 32'(wr_err6), 32'd0);
    en6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ring6_state%0d", i), 32'(state6), 32'(seq6[i]));
    end
    en6 = 1'b0;

    // Async reset between edges restores state, counter and default table
    en = 1'b1;
    tick();
    chk("pre_rst_state", 32'(state), 32'd7);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd1);
    chk("async_rst_cnt", 32'(step_cnt), 32'd0);
    chk("async_rst_wr_err", 32'(wr_err), 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_tbl_state%0d", i), 32'(state), 32'(seq_ring[i]));
      chk($sformatf("rst_tbl_y%0d", i), 32'(y), 32'd0);
      chk($sformatf("rst_tbl_stuck%0d", i), 32'(stuck), 32'd0);
    end
    chk("rst_tbl_cnt", 32'(step_cnt), 32'd4);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/table_fsm.md
TABLE_FSM -- requirements
Module: table_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 3, state encoding width in bits.
REQ-002 SHALL have parameter NUM_STATES, default 8, number of legal states; legal range 2..2**STATE_W.
REQ-003 SHALL have parameter RESET_STATE, default 1, state entered on reset and on restart; legal range < NUM_STATES.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  advance one transition this cycle.
REQ-007 SHALL have port restart  input  1  synchronous return to RESET_STATE.
REQ-008 SHALL have port wr_en  input  1  transition-table write strobe.
REQ-009 SHALL have port wr_addr  input  STATE_W  table entry (source state) to write.
REQ-010 SHALL have port wr_next  input  STATE_W  next-state value to store.
REQ-011 SHALL have port wr_flag  input  1  y-flag value to store for that state.
REQ-012 SHALL have port clr_cnt  input  1  synchronous clear of step_cnt.
REQ-013 SHALL have port state  output  STATE_W  current state, registered.
REQ-014 SHALL have port y  output  1  flag of current state.
REQ-015 SHALL have port stuck  output  1  current state's table entry points to itself.
REQ-016 SHALL have port wr_err  output  1  one-cycle pulse, rejected write.
REQ-017 SHALL have port step_cnt  output  16  count of transitions taken.

Function
REQ-018 SHALL hold a NUM_STATES-entry table, each entry {next[STATE_W], flag}.
REQ-019 SHALL, when en=1 and restart=0, load state with table[state].next on the rising clk edge; en=0 holds state.
REQ-020 SHALL give restart priority over en; restart=1 loads RESET_STATE and does not increment step_cnt.
REQ-021 SHALL drive y = table[state].flag and stuck = (table[state].next == state) combinationally from registered state and table; no further latency.
REQ-022 SHALL write table[wr_addr] on the clk edge when wr_en=1 and wr_addr < NUM_STATES and wr_next < NUM_STATES.
REQ-023 SHALL reject a write with wr_addr >= NUM_STATES or wr_next >= NUM_STATES, leave the table unchanged, and pulse wr_err high for exactly the following cycle.
REQ-024 SHALL, on a simultaneous write to table[state] and en=1, take the transition using the pre-write entry; the new entry applies from the next cycle.
REQ-025 SHALL increment step_cnt by 1 on each cycle with en=1 and restart=0, including self-loop transitions, saturating at 16'hFFFF.
REQ-026 SHALL give clr_cnt priority over increment; step_cnt reads 0 the cycle after clr_cnt.
REQ-027 SHALL treat an out-of-range state value (possible only when NUM_STATES < 2**STATE_W) as illegal and force the next state to RESET_STATE regardless of en.

Reset
REQ-028 SHALL, on reset assertion, immediately set state=RESET_STATE, step_cnt=0, wr_err=0.
REQ-029 SHALL, on reset, initialise table[i].next = (i+1) mod NUM_STATES and table[i].flag = 0 for every i.
REQ-030 SHALL let reset abort any in-progress write; no partial entry survives.

Structure
REQ-031 SHALL place the default-table function and table-entry struct typedef in shared package table_fsm_pkg.
REQ-032 SHALL implement the table as one sub-module fsm_table_ram: register array, synchronous write, asynchronous read, reset initialisation.

Verification (defaults, RESET_STATE=1)
REQ-033 SHALL check: reset, en=1 for 8 cycles -> state 1,2,...,7,0,1; y=0; step_cnt=8.
REQ-034 SHALL check: program 1->5 flag0, 5->7 flag1, 7->3 flag1, 3->2, 2->3; restart; en=1 -> state 1,5,7,3,2,3,2; y=1 only in states 5 and 7.
REQ-035 SHALL check: write 4->4, drive to 4 -> stuck=1, state stays 4, step_cnt keeps incrementing.
REQ-036 SHALL check: wr_next=3'd7 with NUM_STATES=6 -> wr_err pulses 1 cycle, table unchanged.
REQ-037 SHALL check: write to table[state] same cycle as en -> old next taken, new entry used next cycle.
REQ-038 SHALL check: reset asserted mid-sequence between clk edges -> state=1 and step_cnt=0 before the next edge; default table restored.
